// File: rtl/hazard_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_pkg
//
// Shared definitions for the hazard/forwarding unit of the five-stage pipeline:
//   - FWD_RF / FWD_EX / FWD_MEM / FWD_WB : operand source select encodings
//   - fwd_sel_t                          : type of an operand select
//   - hfu_state_t                        : load-use stall FSM states (RUN, LSTALL)
// -----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } hfu_state_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_if
//
// Bundle between the pipeline datapath and the hazard/forwarding unit.
//   ID_RS, ID_RT          : source register specifiers of the instruction in ID
//   ID_USES_RS/ID_USES_RT : ID instruction actually reads rs / rt
//   ID_RF_ENABLE          : ID instruction writes the register file
//   ID_LOAD_INSTR         : ID instruction is a load
//   ID_DEST               : already-selected destination register of ID instruction
//   FLUSH                 : squash the instruction in ID (taken branch/jump)
//   FWD_A_SEL/FWD_B_SEL   : operand source, 00 RF / 01 EX / 10 MEM / 11 WB
//   STALL                 : hold PC and IF/ID
//   BUBBLE                : zero the ID/EX control signals this cycle
//   STALL_COUNT           : saturating count of load-use stall cycles
//
// Modports:
//   master : the pipeline side, drives ID information and consumes decisions
//   slave  : the hazard unit side
// -----------------------------------------------------------------------------
interface hazard_forward_unit_if
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);

    logic [REG_W-1:0] ID_RS;
    logic [REG_W-1:0] ID_RT;
    logic             ID_USES_RS;
    logic             ID_USES_RT;
    logic             ID_RF_ENABLE;
    logic             ID_LOAD_INSTR;
    logic [REG_W-1:0] ID_DEST;
    logic             FLUSH;

    fwd_sel_t         FWD_A_SEL;
    fwd_sel_t         FWD_B_SEL;
    logic             STALL;
    logic             BUBBLE;
    logic [CNT_W-1:0] STALL_COUNT;

    modport master (
        output ID_RS, ID_RT, ID_USES_RS, ID_USES_RT,
               ID_RF_ENABLE, ID_LOAD_INSTR, ID_DEST, FLUSH,
        input  FWD_A_SEL, FWD_B_SEL, STALL, BUBBLE, STALL_COUNT
    );

    modport slave (
        input  ID_RS, ID_RT, ID_USES_RS, ID_USES_RT,
               ID_RF_ENABLE, ID_LOAD_INSTR, ID_DEST, FLUSH,
        output FWD_A_SEL, FWD_B_SEL, STALL, BUBBLE, STALL_COUNT
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//
// Computes the forwarding source for one source operand of the ID instruction.
// A stage matches only if it is going to write the operand register, and the
// youngest matching stage wins (EX > MEM > WB > RF).
//
// Ports:
//   src                : operand register specifier
//   uses               : the ID instruction actually reads this operand
//   ex_wr/mem_wr/wb_wr : stage holds a valid instruction that writes the RF
//   ex_dest/...        : destination register of each stage
//   sel                : resulting operand source select
//   ex_hit             : EX stage writes this operand (feeds load-use detection)
// -----------------------------------------------------------------------------
module fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = 5
)
(
    input  logic [REG_W-1:0] src,
    input  logic             uses,
    input  logic             ex_wr,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             wb_wr,
    input  logic [REG_W-1:0] wb_dest,
    output fwd_sel_t         sel,
    output logic             ex_hit
);

    logic live;
    logic mem_hit;
    logic wb_hit;

    // Register 0 is hard-wired to zero and an unread operand needs no data,
    // so neither ever takes a forwarded value.
    assign live    = uses && (src != '0);
    assign ex_hit  = live && ex_wr  && (ex_dest  == src);
    assign mem_hit = live && mem_wr && (mem_dest == src);
    assign wb_hit  = live && wb_wr  && (wb_dest  == src);

    // The youngest producer holds the architecturally current value.
    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Tracks shadow copies of the EX, MEM and WB stages and, from them, decides
// operand forwarding for the instruction in ID and detects load-use hazards.
// A load-use hazard stalls exactly one cycle; FLUSH always overrides a stall.
//
// Ports:
//   Clk   : pipeline clock, all state updates on the rising edge
//   Reset : synchronous, active-high; clears shadows, FSM and stall counter
//   hfu   : hazard_forward_unit_if.slave bundle (ID info in, decisions out)
//
// Parameters:
//   REG_W : register specifier width
//   CNT_W : stall counter width
// -----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
)
(
    input  logic                  Clk,
    input  logic                  Reset,
    hazard_forward_unit_if.slave  hfu
);

    // Only the EX shadow needs the load flag: a load can only cause a hazard
    // while it is one stage ahead of its consumer. Later stages just forward.
    typedef struct packed {
        logic             valid;
        logic             rf_en;
        logic             load;
        logic [REG_W-1:0] dest;
    } ex_stage_t;

    typedef struct packed {
        logic             valid;
        logic             rf_en;
        logic [REG_W-1:0] dest;
    } wr_stage_t;

    ex_stage_t  ex_q;
    wr_stage_t  mem_q;
    wr_stage_t  wb_q;

    hfu_state_t state_q;
    hfu_state_t state_d;

    logic [CNT_W-1:0] stall_count_q;

    fwd_sel_t sel_a;
    fwd_sel_t sel_b;
    logic     ex_hit_a;
    logic     ex_hit_b;
    logic     load_use;
    logic     stall;
    logic     bubble;

    // Per-operand forwarding selection.
    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .src      (hfu.ID_RS),
        .uses     (hfu.ID_USES_RS),
        .ex_wr    (ex_q.valid && ex_q.rf_en),
        .ex_dest  (ex_q.dest),
        .mem_wr   (mem_q.valid && mem_q.rf_en),
        .mem_dest (mem_q.dest),
        .wb_wr    (wb_q.valid && wb_q.rf_en),
        .wb_dest  (wb_q.dest),
        .sel      (sel_a),
        .ex_hit   (ex_hit_a)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .src      (hfu.ID_RT),
        .uses     (hfu.ID_USES_RT),
        .ex_wr    (ex_q.valid && ex_q.rf_en),
        .ex_dest  (ex_q.dest),
        .mem_wr   (mem_q.valid && mem_q.rf_en),
        .mem_dest (mem_q.dest),
        .wb_wr    (wb_q.valid && wb_q.rf_en),
        .wb_dest  (wb_q.dest),
        .sel      (sel_b),
        .ex_hit   (ex_hit_b)
    );

    // An EX-stage match on a load means the data does not exist yet.
    assign load_use = ex_q.load && (ex_hit_a || ex_hit_b);

    // Shadow pipeline: advances every cycle; a bubble (stall or flush) enters
    // EX as an invalid slot while the held ID instruction waits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{valid: ex_q.valid, rf_en: ex_q.rf_en, dest: ex_q.dest};
            if (bubble) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{valid: 1'b1,
                          rf_en: hfu.ID_RF_ENABLE,
                          load:  hfu.ID_LOAD_INSTR,
                          dest:  hfu.ID_DEST};
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a stall lasts exactly one cycle, after which the load
    // has moved to MEM and can be forwarded.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (stall) state_d = LSTALL;
            LSTALL:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs. In LSTALL the EX shadow is already a bubble so a hazard
    // cannot be seen there; gating by RUN keeps the one-cycle guarantee
    // explicit. FLUSH squashes the consumer, so it wins over a stall.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        if (Reset) begin
            bubble = 1'b1;
        end else begin
            stall  = (state_q == RUN) && load_use && !hfu.FLUSH;
            bubble = stall || hfu.FLUSH;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign hfu.STALL       = stall;
    assign hfu.BUBBLE      = bubble;
    assign hfu.FWD_A_SEL   = Reset ? FWD_RF : sel_a;
    assign hfu.FWD_B_SEL   = Reset ? FWD_RF : sel_b;
    assign hfu.STALL_COUNT = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Self-checking bench for hazard_forward_unit. A behavioural model keeps the
// last three issued instructions (EX, MEM, WB) as a plain array and derives the
// expected forwarding selects, stall, bubble and stall count from the pipeline
// rules. Directed sequences with hand-computed literals are followed by a
// saturation run (small CNT_W) and a randomized run.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic Clk = 1'b0;
    logic Reset;

    hazard_forward_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    hazard_forward_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hfu   (bus)
    );

    always #5 Clk = ~Clk;

    // Model: an in-flight instruction and the three stages ahead of ID.
    typedef struct {
        bit valid;
        int dest;
        bit rf_en;
        bit load;
    } shadow_t;

    shadow_t pipe [3];     // 0 = EX, 1 = MEM, 2 = WB
    int      model_count = 0;
    int      errors      = 0;
    int      checks      = 0;
    bit      checking    = 1'b0;

    function automatic bit stage_writes(shadow_t s, int r);
        return s.valid && s.rf_en && (s.dest == r) && (r != 0);
    endfunction

    // Youngest stage holding the value wins; code is the stage distance.
    function automatic int expected_sel(int r, bit uses);
        if (Reset || !uses) return 0;
        for (int i = 0; i < 3; i++) begin
            if (stage_writes(pipe[i], r)) return i + 1;
        end
        return 0;
    endfunction

    function automatic bit expected_stall();
        bit hazard;
        hazard = pipe[0].load &&
                 ((bus.ID_USES_RS && stage_writes(pipe[0], int'(bus.ID_RS))) ||
                  (bus.ID_USES_RT && stage_writes(pipe[0], int'(bus.ID_RT))));
        return !Reset && hazard && !bus.FLUSH;
    endfunction

    function automatic bit expected_bubble();
        return Reset || bus.FLUSH || expected_stall();
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model advance on each rising edge, from the inputs present at the edge.
    always @(posedge Clk) begin
        bit stall_now;
        bit bubble_now;
        if (Reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 0, 1'b0, 1'b0};
            model_count = 0;
        end else begin
            stall_now  = expected_stall();
            bubble_now = expected_bubble();
            if (stall_now && model_count < CNT_MAX) model_count++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (bubble_now)
                pipe[0] = '{1'b0, 0, 1'b0, 1'b0};
            else
                pipe[0] = '{1'b1, int'(bus.ID_DEST), bus.ID_RF_ENABLE, bus.ID_LOAD_INSTR};
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (checking) begin
            check_output("model_fwd_a",  32'(bus.FWD_A_SEL),
                         32'(expected_sel(int'(bus.ID_RS), bus.ID_USES_RS)));
            check_output("model_fwd_b",  32'(bus.FWD_B_SEL),
                         32'(expected_sel(int'(bus.ID_RT), bus.ID_USES_RT)));
            check_output("model_stall",  32'(bus.STALL),  32'(expected_stall()));
            check_output("model_bubble", 32'(bus.BUBBLE), 32'(expected_bubble()));
            check_output("model_count",  32'(bus.STALL_COUNT), 32'(model_count));
        end
    end

    // One cycle of ID-stage stimulus; returns at the following falling edge.
    task automatic apply_stimulus(input bit rst, input int rs, input bit urs,
                                  input int rt, input bit urt, input bit rfen,
                                  input bit load, input int dest, input bit flush);
        @(posedge Clk);
        #1;
        Reset             = rst;
        bus.ID_RS         = REG_W'(rs);
        bus.ID_USES_RS    = urs;
        bus.ID_RT         = REG_W'(rt);
        bus.ID_USES_RT    = urt;
        bus.ID_RF_ENABLE  = rfen;
        bus.ID_LOAD_INSTR = load;
        bus.ID_DEST       = REG_W'(dest);
        bus.FLUSH         = flush;
        @(negedge Clk);
    endtask

    task automatic nop();
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        Reset             = 1'b1;
        bus.ID_RS         = '0;
        bus.ID_RT         = '0;
        bus.ID_USES_RS    = 1'b0;
        bus.ID_USES_RT    = 1'b0;
        bus.ID_RF_ENABLE  = 1'b0;
        bus.ID_LOAD_INSTR = 1'b0;
        bus.ID_DEST       = '0;
        bus.FLUSH         = 1'b0;

        // Reset: outputs are forced while Reset is high.
        apply_stimulus(1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checking = 1'b1;
        apply_stimulus(1'b1, 3, 1'b1, 4, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        check_output("rst_stall",  32'(bus.STALL),       32'd0);
        check_output("rst_bubble", 32'(bus.BUBBLE),      32'd1);
        check_output("rst_fwd_a",  32'(bus.FWD_A_SEL),   32'd0);
        check_output("rst_fwd_b",  32'(bus.FWD_B_SEL),   32'd0);
        check_output("rst_count",  32'(bus.STALL_COUNT), 32'd0);

        // ADD $3 then consumer of $3 forwards from EX.
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        apply_stimulus(1'b0, 3, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8, 1'b0);
        check_output("add_ex_fwd_a", 32'(bus.FWD_A_SEL), 32'd1);
        check_output("add_ex_stall", 32'(bus.STALL),     32'd0);
        nop(); nop(); nop();

        // LW $5 then ADD rs=$5 rt=$5: one stall cycle, then both from MEM.
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        apply_stimulus(1'b0, 5, 1'b1, 5, 1'b1, 1'b1, 1'b0, 6, 1'b0);
        check_output("lu_stall",  32'(bus.STALL),  32'd1);
        check_output("lu_bubble", 32'(bus.BUBBLE), 32'd1);
        apply_stimulus(1'b0, 5, 1'b1, 5, 1'b1, 1'b1, 1'b0, 6, 1'b0);
        check_output("lu_held_stall", 32'(bus.STALL),       32'd0);
        check_output("lu_held_bub",   32'(bus.BUBBLE),      32'd0);
        check_output("lu_held_fwd_a", 32'(bus.FWD_A_SEL),   32'd2);
        check_output("lu_held_fwd_b", 32'(bus.FWD_B_SEL),   32'd2);
        check_output("lu_count",      32'(bus.STALL_COUNT), 32'd1);

        // ADD $4, NOP, NOP, read rt=$4 -> WB.
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        nop(); nop();
        apply_stimulus(1'b0, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check_output("wb_fwd_b", 32'(bus.FWD_B_SEL), 32'd3);

        // ADD $4 twice, then read rs=$4 -> EX has priority over MEM.
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        apply_stimulus(1'b0, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_output("prio_fwd_a", 32'(bus.FWD_A_SEL), 32'd1);

        // ADD $0 then read $0 on both operands -> RF.
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check_output("r0_fwd_a", 32'(bus.FWD_A_SEL), 32'd0);
        check_output("r0_fwd_b", 32'(bus.FWD_B_SEL), 32'd0);

        // LW $7 with the consumer flushed: no stall, bubble, FSM stays RUN.
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 7, 1'b0);
        apply_stimulus(1'b0, 7, 1'b1, 0, 1'b0, 1'b1, 1'b0, 9, 1'b1);
        check_output("flush_stall",  32'(bus.STALL),  32'd0);
        check_output("flush_bubble", 32'(bus.BUBBLE), 32'd1);
        apply_stimulus(1'b0, 7, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_output("post_flush_stall", 32'(bus.STALL),       32'd0);
        check_output("post_flush_fwd_a", 32'(bus.FWD_A_SEL),   32'd2);
        check_output("post_flush_count", 32'(bus.STALL_COUNT), 32'd1);

        // Reset asserted while in the stall cycle.
        apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 9, 1'b0);
        apply_stimulus(1'b0, 9, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_output("pre_rst_stall", 32'(bus.STALL), 32'd1);
        apply_stimulus(1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_output("mid_rst_stall",  32'(bus.STALL),     32'd0);
        check_output("mid_rst_bubble", 32'(bus.BUBBLE),    32'd1);
        check_output("mid_rst_fwd_a",  32'(bus.FWD_A_SEL), 32'd0);
        apply_stimulus(1'b0, 9, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_output("after_rst_stall",  32'(bus.STALL),       32'd0);
        check_output("after_rst_bubble", 32'(bus.BUBBLE),      32'd0);
        check_output("after_rst_fwd_a",  32'(bus.FWD_A_SEL),   32'd0);
        check_output("after_rst_count",  32'(bus.STALL_COUNT), 32'd0);

        // Back-to-back dependent loads stall every other cycle; drive more
        // than 2^CNT_W+5 stalls and expect the counter pinned at all-ones.
        for (int i = 0; i < 2 * ((1 << CNT_W) + 5) + 2; i++) begin
            apply_stimulus(1'b0, 5, 1'b1, 0, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        end
        check_output("sat_count", 32'(bus.STALL_COUNT), 32'(CNT_MAX));

        // Randomized traffic over a small register range to force collisions.
        for (int i = 0; i < 600; i++) begin
            apply_stimulus(($urandom_range(0, 39) == 0),
                           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                           int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
        end

        @(posedge Clk);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
